// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory and write-back stages.
// The MEM/WB record layout is common to both stages so the WB stage can unpack it directly.
package mem_stage_pkg;

    localparam int REG_W  = 3;
    localparam int WORD_W = 8;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic              write_reg;
        logic [REG_W-1:0]  rd;
        logic [WORD_W-1:0] wb_data;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_data_ram.sv
// Data RAM for the memory stage: synchronous write, asynchronous read, contents never reset.
module mem_stage_data_ram #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DATA_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read is combinational, so a load sees the value present before this edge's write.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: multi-cycle load/store sequencing, upstream stall and the MEM/WB register.
//
//  state | meaning
//  IDLE  | accepting; ALU ops and single-cycle memory ops retire straight from here
//  WAIT  | multi-cycle memory access in flight; cnt counts cycles already occupied
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              write_mem_i,
    input  logic              read_mem_i,
    input  logic              write_reg_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] aluOut_i,
    input  logic [REG_W-1:0]  reg1_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic              write_reg_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              fwd_en_o
);

    localparam logic [1:0] CNT_LAST    = 2'(MEM_LAT - 1);
    localparam bit         MULTI_CYCLE = (MEM_LAT > 1);

    mem_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              write_reg_q, write_reg_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              mem_op;
    logic              stall;
    logic              consume;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign mem_op = valid_i & (read_mem_i | write_mem_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        write_reg_d = 1'b0;
        rd_d        = rd_q;
        wb_data_d   = wb_data_q;
        stall       = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall = mem_op & MULTI_CYCLE;
                if (stall && !flush_i) begin
                    state_d = WAIT;
                    cnt_d   = 2'd1;
                end
            end
            WAIT: begin
                stall = (cnt_q != CNT_LAST);
                if (flush_i || !stall) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
        endcase

        if (reset) begin
            stall = 1'b0;
        end

        // Only the consuming edge touches the RAM or loads a real instruction into MEM/WB;
        // every other edge, including stall edges, shifts a bubble in.
        consume = valid_i & ~stall & ~flush_i & ~reset;
        if (consume) begin
            valid_d     = 1'b1;
            write_reg_d = write_reg_i;
            rd_d        = reg1_i;
            wb_data_d   = (read_mem_i && !write_mem_i) ? ram_rdata : aluOut_i;
        end
    end

    assign ram_we = consume & write_mem_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            valid_q     <= 1'b0;
            write_reg_q <= 1'b0;
            rd_q        <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            write_reg_q <= write_reg_d;
            rd_q        <= rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    mem_stage_data_ram #(
        .DATA_W (DATA_W)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (aluOut_i),
        .wdata_i (data2_i),
        .rdata_o (ram_rdata)
    );

    assign stall_o     = stall;
    assign valid_o     = valid_q;
    assign write_reg_o = write_reg_q;
    assign rd_o        = rd_q;
    assign wb_data_o   = wb_data_q;
    assign fwd_en_o    = valid_q & write_reg_q;

endmodule
